// File: rtl/async_fifo_wr_ctrl_if.sv
// Write-side port bundle of the async FIFO controller (W_ALMOST_FULL only with WR_CTRL_ALMOST_FULL_EN).
// master = producer / read-domain side, slave = write controller.
interface async_fifo_wr_ctrl_if #(
    parameter int AW = 3
);
    logic          W_INC;
    logic [AW:0]   r_ptr_gray;
    logic [AW-1:0] w_addr;
    logic [AW:0]   w_ptr_gray;
    logic          W_FULL;
    logic          W_OVERFLOW;
`ifdef WR_CTRL_ALMOST_FULL_EN
    logic          W_ALMOST_FULL;
`endif

    modport master (
        output W_INC,
        output r_ptr_gray,
        input  w_addr,
        input  w_ptr_gray,
        input  W_FULL,
`ifdef WR_CTRL_ALMOST_FULL_EN
        input  W_ALMOST_FULL,
`endif
        input  W_OVERFLOW
    );

    modport slave (
        input  W_INC,
        input  r_ptr_gray,
        output w_addr,
        output w_ptr_gray,
        output W_FULL,
`ifdef WR_CTRL_ALMOST_FULL_EN
        output W_ALMOST_FULL,
`endif
        output W_OVERFLOW
    );
endinterface

// File: rtl/async_fifo_wr_ctrl.sv
// Async FIFO write controller: Gray write pointer, read-pointer synchronizer, registered full/sticky overflow (W_ALMOST_FULL under WR_CTRL_ALMOST_FULL_EN).
// Full rises on the filling write edge and falls SYNC_STAGES+1 edges after r_ptr_gray moves; writes while full are dropped and flagged.
module async_fifo_wr_ctrl #(
    parameter int DEPTH        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int AF_THRESHOLD = DEPTH - 2
) (
    input  logic                W_CLK,
    input  logic                W_RST,
    async_fifo_wr_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || SYNC_STAGES < 2 ||
        AF_THRESHOLD < 0 || AF_THRESHOLD > DEPTH) begin : g_bad_param
        $error("async_fifo_wr_ctrl: illegal parameter combination");
    end

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] wgray_q;
    logic [PW-1:0] rq_sync [SYNC_STAGES];
    logic [PW-1:0] rq_last;
    logic          accept;
    logic          full_q;
    logic          full_next;
    logic          ovf_q;

    assign accept     = bus.W_INC & ~full_q;
    assign wbin_next  = wbin + PW'(accept);
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign rq_last    = rq_sync[SYNC_STAGES-1];
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign full_next  = (wgray_next == {~rq_last[AW:AW-1], rq_last[AW-2:0]});

    always_ff @(posedge W_CLK) begin
        if (W_RST) begin
            wbin    <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rq_sync[i] <= '0;
            end
        end else begin
            wbin    <= wbin_next;
            wgray_q <= wgray_next;
            full_q  <= full_next;
            if (bus.W_INC && full_q) begin
                ovf_q <= 1'b1;
            end
            rq_sync[0] <= bus.r_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rq_sync[i] <= rq_sync[i-1];
            end
        end
    end

    assign bus.w_addr     = wbin[AW-1:0];
    assign bus.w_ptr_gray = wgray_q;
    assign bus.W_FULL     = full_q;
    assign bus.W_OVERFLOW = ovf_q;

`ifdef WR_CTRL_ALMOST_FULL_EN
    logic [PW-1:0] rbin;
    logic [PW-1:0] fill;
    logic          af_q;

    // Binary bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(rq_last >> i);
        end
    end

    assign fill = wbin_next - rbin;

    always_ff @(posedge W_CLK) begin
        if (W_RST) begin
            af_q <= 1'b0;
        end else begin
            af_q <= (fill >= PW'(AF_THRESHOLD));
        end
    end

    assign bus.W_ALMOST_FULL = af_q;
`endif
endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for async_fifo_wr_ctrl at DEPTH=8, SYNC_STAGES=2.
module tb_async_fifo_wr_ctrl;
    logic W_CLK = 1'b0;
    logic W_RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    async_fifo_wr_ctrl_if #(.AW(3)) bus ();

    async_fifo_wr_ctrl #(
        .DEPTH        (8),
        .SYNC_STAGES  (2),
        .AF_THRESHOLD (6)
    ) dut (
        .W_CLK (W_CLK),
        .W_RST (W_RST),
        .bus   (bus)
    );

    always #5 W_CLK = ~W_CLK;

    task automatic tick;
        @(posedge W_CLK);
        #1;
    endtask

    task automatic test_reset;
        W_RST = 1'b1;
        bus.W_INC = 1'b1;
        bus.r_ptr_gray = 4'b0000;
        tick();
        checks++; if (bus.w_addr !== 3'd0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.w_addr); end
        checks++; if (bus.w_ptr_gray !== 4'b0000) begin errors++; $display("FAIL reset_gray got %b want 0000", bus.w_ptr_gray); end
        checks++; if (bus.W_FULL !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.W_FULL); end
        checks++; if (bus.W_OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.W_OVERFLOW); end
        W_RST = 1'b0;
    endtask

    task automatic test_fill;
        logic [3:0] g_tab [8];
        g_tab = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
        bus.W_INC = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++; if (bus.w_addr !== 3'(i)) begin errors++; $display("FAIL fill_addr[%0d] got %h want %h", i, bus.w_addr, 3'(i)); end
            checks++; if (bus.w_ptr_gray !== g_tab[i-1]) begin errors++; $display("FAIL fill_gray[%0d] got %b want %b", i, bus.w_ptr_gray, g_tab[i-1]); end
            checks++; if (bus.W_FULL !== (i == 8)) begin errors++; $display("FAIL fill_full[%0d] got %b want %b", i, bus.W_FULL, (i == 8)); end
            checks++; if (bus.W_OVERFLOW !== 1'b0) begin errors++; $display("FAIL fill_ovf[%0d] got %b want 0", i, bus.W_OVERFLOW); end
        end
    endtask

    task automatic test_overflow;
        bus.W_INC = 1'b1;
        tick();
        checks++; if (bus.w_addr !== 3'd0) begin errors++; $display("FAIL ovf_addr got %h want 0", bus.w_addr); end
        checks++; if (bus.w_ptr_gray !== 4'b1100) begin errors++; $display("FAIL ovf_gray got %b want 1100", bus.w_ptr_gray); end
        checks++; if (bus.W_OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", bus.W_OVERFLOW); end
        checks++; if (bus.W_FULL !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", bus.W_FULL); end
        bus.W_INC = 1'b0;
        tick();
        checks++; if (bus.W_OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", bus.W_OVERFLOW); end
        checks++; if (bus.w_addr !== 3'd0) begin errors++; $display("FAIL ovf_idle_addr got %h want 0", bus.w_addr); end
    endtask

    task automatic test_full_release;
        bus.W_INC = 1'b0;
        bus.r_ptr_gray = 4'b0001;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++; if (bus.W_FULL !== (e < 3)) begin errors++; $display("FAIL release_full[edge %0d] got %b want %b", e, bus.W_FULL, (e < 3)); end
        end
        bus.W_INC = 1'b1;
        tick();
        checks++; if (bus.w_addr !== 3'd1) begin errors++; $display("FAIL release_addr got %h want 1", bus.w_addr); end
        checks++; if (bus.w_ptr_gray !== 4'b1101) begin errors++; $display("FAIL release_gray got %b want 1101", bus.w_ptr_gray); end
        checks++; if (bus.W_FULL !== 1'b1) begin errors++; $display("FAIL refull got %b want 1", bus.W_FULL); end
        bus.W_INC = 1'b0;
    endtask

    task automatic test_wrap;
        logic [3:0] hist [17];
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] prev;
        W_RST = 1'b1;
        bus.W_INC = 1'b0;
        bus.r_ptr_gray = 4'b0000;
        tick();
        W_RST = 1'b0;
        checks++; if (bus.W_OVERFLOW !== 1'b0) begin errors++; $display("FAIL wrap_rst_ovf got %b want 0", bus.W_OVERFLOW); end
        b = 4'd0;
        prev = 4'b0000;
        hist[0] = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            if (k >= 4) bus.r_ptr_gray = hist[k-4];
            else        bus.r_ptr_gray = 4'b0000;
            bus.W_INC = 1'b1;
            tick();
            b = b + 4'd1;
            g = b ^ (b >> 1);
            hist[k+1] = g;
            checks++; if (bus.w_ptr_gray !== g) begin errors++; $display("FAIL wrap_gray[%0d] got %b want %b", k, bus.w_ptr_gray, g); end
            checks++; if ($countones(bus.w_ptr_gray ^ prev) != 1) begin errors++; $display("FAIL wrap_onebit[%0d] got %b prev %b want one bit change", k, bus.w_ptr_gray, prev); end
            checks++; if (bus.W_FULL !== 1'b0) begin errors++; $display("FAIL wrap_full[%0d] got %b want 0", k, bus.W_FULL); end
            prev = g;
        end
        bus.W_INC = 1'b0;
        checks++; if (bus.w_ptr_gray !== 4'b0000) begin errors++; $display("FAIL wrap_final got %b want 0000", bus.w_ptr_gray); end
    endtask

    task automatic test_reset_mid_burst;
        bus.r_ptr_gray = 4'b0000;
        bus.W_INC = 1'b1;
        repeat (3) tick();
        W_RST = 1'b1;
        tick();
        checks++; if (bus.w_addr !== 3'd0) begin errors++; $display("FAIL midrst_addr got %h want 0", bus.w_addr); end
        checks++; if (bus.w_ptr_gray !== 4'b0000) begin errors++; $display("FAIL midrst_gray got %b want 0000", bus.w_ptr_gray); end
        checks++; if (bus.W_FULL !== 1'b0) begin errors++; $display("FAIL midrst_full got %b want 0", bus.W_FULL); end
        checks++; if (bus.W_OVERFLOW !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b want 0", bus.W_OVERFLOW); end
        W_RST = 1'b0;
        tick();
        checks++; if (bus.w_addr !== 3'd1) begin errors++; $display("FAIL first_write_addr got %h want 1", bus.w_addr); end
        checks++; if (bus.w_ptr_gray !== 4'b0001) begin errors++; $display("FAIL first_write_gray got %b want 0001", bus.w_ptr_gray); end
        bus.W_INC = 1'b0;
    endtask

`ifdef WR_CTRL_ALMOST_FULL_EN
    task automatic test_almost_full;
        W_RST = 1'b1;
        bus.W_INC = 1'b0;
        bus.r_ptr_gray = 4'b0000;
        tick();
        W_RST = 1'b0;
        checks++; if (bus.W_ALMOST_FULL !== 1'b0) begin errors++; $display("FAIL af_reset got %b want 0", bus.W_ALMOST_FULL); end
        bus.W_INC = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++; if (bus.W_ALMOST_FULL !== (i >= 6)) begin errors++; $display("FAIL af[%0d] got %b want %b", i, bus.W_ALMOST_FULL, (i >= 6)); end
        end
        W_RST = 1'b1;
        tick();
        checks++; if (bus.W_ALMOST_FULL !== 1'b0) begin errors++; $display("FAIL af_midrst got %b want 0", bus.W_ALMOST_FULL); end
        checks++; if (bus.w_addr !== 3'd0) begin errors++; $display("FAIL af_midrst_addr got %h want 0", bus.w_addr); end
        W_RST = 1'b0;
        bus.W_INC = 1'b0;
    endtask
`endif

    initial begin
        bus.W_INC = 1'b0;
        bus.r_ptr_gray = 4'b0000;
        test_reset();
        test_fill();
        test_overflow();
        test_full_release();
        test_wrap();
        test_reset_mid_burst();
`ifdef WR_CTRL_ALMOST_FULL_EN
        test_almost_full();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
